// File: rtl/data_memory_responder.sv
// Data-memory responder for the M stage: one request at a time,
// fixed-latency access to a word array, valid/ready response channel.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          misal;
    logic          err;
    logic          execute;
    logic [IW-1:0] idx;
    logic [31:0]   rword;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [31:0]   ld;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign misal = (size_q == 2'd1 && addr_q[0]) ||
                   (size_q == 2'd2 && addr_q[1:0] != 2'b00);
    assign err = (size_q == 2'd3) || misal ||
                 (addr_q[31:2] >= DEPTH_W);
    assign execute = (state_q == BUSY) && (cnt_q == '0);
    assign idx = addr_q[IW+1:2];
    assign rword = mem[idx];

    // Select and extend the addressed byte/half of the word
    always_comb begin
        ld_b = rword[{addr_q[1:0], 3'b000} +: 8];
        ld_h = addr_q[1] ? rword[31:16] : rword[15:0];
        ld   = rword;
        unique case (size_q)
            2'd0: ld = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'd1: ld = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld = rword;
        endcase
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        be = 4'hf;
        wd = wdata_q;
        unique case (size_q)
            2'd0: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'hf;
                wd = wdata_q;
            end
        endcase
    end

    // Array write on the execute edge; the array itself is never reset
    always_ff @(posedge clk) begin
        if (execute && wr_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Request/countdown/response FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata;
                        cnt_q     <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || wr_q) ? 32'h0 : ld;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: byte-level reference model,
// scoreboard queue, directed cases and randomized traffic.
module tb_data_memory_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc = 0;
    int bp_mode = 0;
    logic prev_v = 1'b0;
    logic [32:0] e;
    logic [32:0] exp_q[$];
    logic [7:0] mdl [4*DEPTH];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Reference: byte-addressed memory, returns {err, rdata}
    function automatic logic [32:0] predict(input logic w,
            input logic [31:0] a, input logic [1:0] s,
            input logic u, input logic [31:0] d);
        int n;
        logic [31:0] v;
        n = 1 << s;
        if (s == 2'd3 || (a % n) != 0 || (a / 4) >= DEPTH)
            return {1'b1, 32'h0};
        if (w) begin
            for (int i = 0; i < n; i++) mdl[a + i] = d[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[a + i]) << (8 * i));
        if (!u && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return {1'b0, v};
    endfunction

    // Monitor: drives resp_ready, checks latency and popped responses
    always @(negedge clk) begin
        case (bp_mode)
            0: resp_ready = 1'b1;
            1: resp_ready = ($urandom % 3) != 0;
            default: resp_ready = 1'b0;
        endcase
        if (rst) begin
            if (resp_valid && !prev_v) chk("latency", cyc - acc, LATENCY);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", resp_rdata, e[31:0]);
                    chk("err", {31'b0, resp_err}, {31'b0, e[32]});
                end
            end
        end
        prev_v = resp_valid;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic u,
                        input logic [31:0] d, input bit fixed,
                        input logic [32:0] want);
        int n;
        logic [32:0] p;
        n = 0;
        @(negedge clk);
        req_write = w;
        req_addr = a;
        req_size = s;
        req_unsigned = u;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        p = predict(w, a, s, u, d);
        exp_q.push_back(fixed ? want : p);
    endtask

    task automatic op(input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic u,
                      input logic [31:0] d);
        send(w, a, s, u, d, 1'b0, 33'h0);
    endtask

    task automatic opx(input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] d, input logic [32:0] want);
        send(w, a, s, u, d, 1'b1, want);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Main stimulus sequence
    initial begin
        int n;
        logic [31:0] hd;
        logic he;
        logic [31:0] a;
        logic [1:0] s;
        int r;
        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        req_wdata = '0;
        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", {31'b0, resp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'b0, req_ready}, 1);

        for (int i = 0; i < 32; i++) op(1, 32'(4 * i), 2, 0, $urandom);
        drain();

        opx(1, 32'h10, 2, 0, 32'hDEADBEEF, {1'b0, 32'h0});
        opx(0, 32'h10, 2, 0, 32'h0, {1'b0, 32'hDEADBEEF});

        opx(1, 32'h20, 2, 0, 32'h80F17F01, {1'b0, 32'h0});
        opx(0, 32'h23, 0, 0, 32'h0, {1'b0, 32'hFFFFFF80});
        opx(0, 32'h23, 0, 1, 32'h0, {1'b0, 32'h00000080});
        opx(0, 32'h22, 1, 0, 32'h0, {1'b0, 32'hFFFF80F1});
        opx(0, 32'h20, 1, 1, 32'h0, {1'b0, 32'h00007F01});

        opx(1, 32'h30, 2, 0, 32'h11223344, {1'b0, 32'h0});
        opx(1, 32'h31, 0, 0, 32'h000000AA, {1'b0, 32'h0});
        opx(1, 32'h32, 1, 0, 32'h0000BBCC, {1'b0, 32'h0});
        opx(0, 32'h30, 2, 0, 32'h0, {1'b0, 32'hBBCCAA44});

        opx(1, 32'h40, 2, 0, 32'h55667788, {1'b0, 32'h0});
        opx(1, 32'h41, 1, 0, 32'hFFFFFFFF, {1'b1, 32'h0});
        opx(0, 32'h42, 2, 0, 32'h0, {1'b1, 32'h0});
        opx(0, 32'h40, 3, 0, 32'h0, {1'b1, 32'h0});
        opx(1, 32'h40, 3, 0, 32'h01010101, {1'b1, 32'h0});
        opx(0, 32'(4 * DEPTH), 2, 0, 32'h0, {1'b1, 32'h0});
        opx(1, 32'(4 * DEPTH), 2, 0, 32'h12121212, {1'b1, 32'h0});
        opx(0, 32'h40, 2, 0, 32'h0, {1'b0, 32'h55667788});
        drain();

        bp_mode = 2;
        @(negedge clk);
        opx(0, 32'h30, 2, 0, 32'h0, {1'b0, 32'hBBCCAA44});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        chk("bp_valid", {31'b0, resp_valid}, 1);
        chk("bp_data", resp_rdata, 32'hBBCCAA44);
        hd = resp_rdata;
        he = resp_err;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                @(posedge clk);
                #1;
                req_write = 1'b1;
                req_addr = 32'h40;
                req_size = 2'd2;
                req_wdata = 32'hBAD0BAD0;
                req_valid = 1'b1;
            end
            if (i == 2) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, resp_valid}, 1);
            chk("bp_hold_rdata", resp_rdata, hd);
            chk("bp_hold_err", {31'b0, resp_err}, {31'b0, he});
            chk("bp_req_ready", {31'b0, req_ready}, 0);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_ready_after", {31'b0, req_ready}, 1);
        opx(0, 32'h40, 2, 0, 32'h0, {1'b0, 32'h55667788});
        drain();

        opx(1, 32'h50, 2, 0, 32'hCAFEF00D, {1'b0, 32'h0});
        drain();
        req_write = 1'b1;
        req_addr = 32'h50;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("abort_req_ready", {31'b0, req_ready}, 0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 0);
        chk("abort_resp_rdata", resp_rdata, 0);
        chk("abort_resp_err", {31'b0, resp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        opx(0, 32'h50, 2, 0, 32'h0, {1'b0, 32'hCAFEF00D});
        drain();

        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            r = $urandom % 8;
            s = (r < 7) ? 2'(r % 3) : 2'd3;
            if ($urandom % 16 == 0) a = 32'(4 * DEPTH + 4 * ($urandom % 8));
            else a = 32'(4 * ($urandom % 32));
            a = a + 32'($urandom % 4);
            op(1'($urandom % 2), a, s, 1'($urandom % 2), $urandom);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the M-stage data-memory port of the pipelined RISC-V core: accepts one load/store request at a time over a valid/ready handshake, services it against an internal word-addressed array after a fixed latency, and returns the result over a valid/ready response channel. Loads are extended to 32 bits by size and signedness. Stores write through per-byte lanes. Misaligned or out-of-range accesses complete with an error and leave the array untouched. The core's memory stage stalls on `req_ready`/`resp_valid`.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; at least 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer takes the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned, out-of-range or illegal-size access.

## Operation
- FSM with three states:
  - IDLE: `req_ready` = 1. On `req_valid && req_ready`, latch write, addr, size, unsigned and wdata, then go to BUSY.
  - BUSY: countdown of LATENCY cycles.
  - RESP: `resp_valid` = 1. On `resp_ready`, go to IDLE.
- Counter: loaded with LATENCY-1 on acceptance and decremented each BUSY cycle. When it reaches 0, the access executes and the FSM moves to RESP on the same edge.
- Error check, evaluated on latched fields:
  - `size == 3` is an error.
  - `size == 1` with `addr[0]` set is an error.
  - `size == 2` with `addr[1:0]` nonzero is an error.
  - `addr[31:2] >= DEPTH_WORDS` is an error.
  - On error: no array write, `resp_rdata` = 0, `resp_err` = 1.
- Load data path:
  - Word index is `addr[31:2]`; the byte or half is selected by `addr[1:0]`.
  - Selected bits go to `resp_rdata[7:0]` or `resp_rdata[15:0]`, extended per `req_unsigned`. Words pass through unchanged.
- Store data path:
  - Byte: lane `addr[1:0]` gets `wdata[7:0]`.
  - Half: lanes `{addr[1],0}` and `{addr[1],1}` get `wdata[15:0]`.
  - Word: all lanes.
  - Other lanes keep their contents. `resp_rdata` = 0.
- The array is not reset; its contents survive `rst`.
- Response outputs stay stable while `resp_valid && !resp_ready`.

## Timing
- Reset values: `req_ready` = 0 while `rst` is low and 1 from the first cycle after release (state IDLE). `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0. Counter = 0.
- Acceptance at edge N puts `resp_valid` high after edge N+LATENCY. With LATENCY = 1, the response is visible in the cycle after acceptance.
- A store's array update occurs at edge N+LATENCY. A load accepted after that response sees the new data.
- Back-to-back rate: if `resp_ready` = 1 when `resp_valid` rises, the next request is accepted no earlier than the cycle after the response handshake. Peak throughput is one access per LATENCY+2 cycles.
- `req_*` inputs are ignored outside IDLE. The requester must hold `req_*` stable until accepted.
- Reset asserted mid-operation: the pending access is dropped. An in-flight store that has not reached edge N+LATENCY does not write. Outputs return to reset values immediately (asynchronous).

## Test plan
- Word round trip: store `0xDEADBEEF` to addr `0x10`, then load word from `0x10`. Load returns `0xDEADBEEF`, `resp_err` = 0, and `resp_valid` rises exactly LATENCY cycles after each acceptance.
- Byte/half extension, with word `0x80F17F01` at `0x20`:
  - signed byte at `0x23` → `0xFFFFFF80`
  - unsigned byte at `0x23` → `0x00000080`
  - signed half at `0x22` → `0xFFFF80F1`
  - unsigned half at `0x20` → `0x00007F01`
- Lane merge: word `0x11223344` at `0x30`, then store byte `0xAA` at `0x31`, then store half `0xBBCC` at `0x32`. Word load at `0x30` returns `0xBBCCAA44`.
- Errors: each case returns `resp_err` = 1, `resp_rdata` = 0, and word `0x40` unchanged.
  - half store at `0x41`
  - word load at `0x42`
  - size 3
  - word access at `4*DEPTH_WORDS`
- Backpressure: hold `resp_ready` = 0 for 5 cycles after `resp_valid` rises. Outputs stay stable, `req_ready` stays 0, and a `req_valid` pulse meanwhile is not accepted. Release → handshake, then `req_ready` = 1 next cycle.
- Reset mid-store: accept a store of `0x12345678` to `0x50` (prior contents `0xCAFEF00D`). Pull `rst` low in BUSY before edge N+LATENCY. Outputs go to 0 asynchronously. After release, a load of `0x50` returns `0xCAFEF00D`.
